// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter.
// State encoding, ALU op codes, data-path widths and a mul/div classifier.
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] OP_ADD = 4'b0000;
    localparam logic [SEL_W-1:0] OP_MUL = 4'b0010;
    localparam logic [SEL_W-1:0] OP_DIV = 4'b0011;

    function automatic logic is_muldiv(input logic [SEL_W-1:0] sel);
        return (sel == OP_MUL) || (sel == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-way round-robin grant.
// The pointer remembers the requester served last; on a tie the other one wins.
// With no request the grant idles toward the not-last requester.
module alu_arb_rr2 #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);

    logic last;

    // Single requester wins outright; a tie goes to whoever was not served last.
    always_comb begin
        grant = ~last;
        if (req == 2'b01)
            grant = 1'b0;
        else if (req == 2'b10)
            grant = 1'b1;
    end

    // Reset marks the other requester as last served so RR_INIT wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= ~RR_INIT;
        else if (advance)
            last <= grant;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between two requesters.
// Round-robin arbitration, registered ALU operands, extra settle cycles for mul/div,
// and a held response carrying the requester ID.
// Optional feature: define ALU_ARB_DIV0_CHECK_EN to short-circuit divide-by-zero
// (rsp_data=8'hFF, rsp_cout=0, rsp_err=1, no settle cycles). Without it rsp_err is 0.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int MULDIV_WAIT = 2,
    parameter int RR_INIT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_cout,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(MULDIV_WAIT);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] win_a;
    logic [DATA_W-1:0] win_b;
    logic [SEL_W-1:0]  win_sel;

    alu_arb_rr2 #(.RR_INIT(1'(RR_INIT))) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    // Ready only toward the granted, valid requester while idle, so at most one is high.
    always_comb begin
        req0_ready = (state == S_IDLE) && req0_valid && (grant == 1'b0);
        req1_ready = (state == S_IDLE) && req1_valid && (grant == 1'b1);
        accept     = req0_ready || req1_ready;
        win_a      = grant ? req1_a   : req0_a;
        win_b      = grant ? req1_b   : req0_b;
        win_sel    = grant ? req1_sel : req0_sel;
    end

    assign busy = (state != S_IDLE);

`ifdef ALU_ARB_DIV0_CHECK_EN
    logic div0_q;
    logic win_div0;
    assign win_div0 = (win_sel == OP_DIV) && (win_b == '0);
`else
    assign rsp_err = 1'b0;
`endif

    // Sequencer: latch the winner, wait out mul/div settling, capture and hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
`ifdef ALU_ARB_DIV0_CHECK_EN
            div0_q    <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_a    <= win_a;
                        alu_b    <= win_b;
                        alu_sel  <= win_sel;
                        rsp_id   <= grant;
                        wait_cnt <= is_muldiv(win_sel) ? WAIT_LD : '0;
`ifdef ALU_ARB_DIV0_CHECK_EN
                        div0_q   <= win_div0;
                        if (win_div0)
                            wait_cnt <= '0;
`endif
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
`ifdef ALU_ARB_DIV0_CHECK_EN
                        if (div0_q) begin
                            rsp_data <= 8'hFF;
                            rsp_cout <= 1'b0;
                            rsp_err  <= 1'b1;
                        end else begin
                            rsp_data <= alu_out;
                            rsp_cout <= alu_cout;
                            rsp_err  <= 1'b0;
                        end
`else
                        rsp_data <= alu_out;
                        rsp_cout <= alu_cout;
`endif
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU beside it.
// Expected responses are pushed to a scoreboard at accept and popped when rsp_valid rises.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int MW = 2;

    logic       clk, rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_sel, req1_sel;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_cout;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err, busy;
    logic [7:0] rsp_data;

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       cout;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    alu_arbiter #(.MULDIV_WAIT(MW), .RR_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [15:0] p;
        case (sel)
            4'b0000: return {1'b0, a} + {1'b0, b};
            4'b0001: return {1'b0, a} - {1'b0, b};
            4'b0010: begin p = a * b; return {|p[15:8], p[7:0]}; end
            4'b0011: return (b == 8'd0) ? 9'h000 : {1'b0, a / b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    assign {alu_cout, alu_out} = alu_model(alu_a, alu_b, alu_sel);

    function automatic exp_t exp_of(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        exp_t e;
        logic [8:0] r;
        r      = alu_model(a, b, sel);
        e.id   = id;
        e.data = r[7:0];
        e.cout = r[8];
        e.err  = 1'b0;
        e.lat  = 2 + (((sel == 4'b0010) || (sel == 4'b0011)) ? MW : 0);
`ifdef ALU_ARB_DIV0_CHECK_EN
        if (sel == 4'b0011 && b == 8'd0) begin
            e.data = 8'hFF;
            e.cout = 1'b0;
            e.err  = 1'b1;
            e.lat  = 2;
        end
`endif
        return e;
    endfunction

    task automatic drive(input logic id, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present an op, wait (bounded) for its ready, push the expectation; returns after the accept edge.
    task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel, output int acc);
        acc = -1;
        drive(id, 1'b1, a, b, sel);
        for (int k = 0; k < 20; k++) begin
            #2;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                acc = cyc;
                sb.push_back(exp_of(id, a, b, sel));
                @(negedge clk);
                drive(id, 1'b0, a, b, sel);
                return;
            end
            @(negedge clk);
        end
        drive(id, 1'b0, a, b, sel);
    endtask

    task automatic wait_rsp(output int seen, output bit ok);
        ok   = 1'b0;
        seen = -1;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (rsp_valid === 1'b1) begin
                seen = cyc;
                ok   = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({alu_a, alu_b, alu_sel} !== 20'h0) begin
            errors++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_sel});
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err} !== 12'h0) begin
            errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err});
        end
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_ready_busy: got %b want 000", {req0_ready, req1_ready, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int acc, seen; bit ok; exp_t e;
        drive(1'b0, 1'b1, 8'd200, 8'd100, OP_ADD);
        #2;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end
        issue(1'b0, 8'd200, 8'd100, OP_ADD, acc);
        wait_rsp(seen, ok);
        checks++;
        if (!ok || acc < 0 || sb.size() == 0) begin
            errors++; $display("FAIL single_timeout: got ok=%0d acc=%0d want response", ok, acc);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        checks++;
        if (seen - acc != e.lat) begin
            errors++; $display("FAIL single_lat: got %0d want %0d", seen - acc, e.lat);
        end
        checks++;
        if ({rsp_id, rsp_data, rsp_cout, rsp_err} !== {1'b0, 8'd44, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_rsp: got id=%0d data=%0d cout=%0d err=%0d want id=0 data=44 cout=1 err=0",
                               rsp_id, rsp_data, rsp_cout, rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        int seen; bit ok; exp_t e; logic w;
        logic exp_order [3];
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
        do_reset();
        rsp_ready = 1'b1;
        drive(1'b0, 1'b1, 8'd1, 8'd2, OP_ADD);
        drive(1'b1, 1'b1, 8'd50, 8'd60, OP_ADD);
        for (int i = 0; i < 3; i++) begin
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                #2;
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!ok || (req0_ready & req1_ready) !== 1'b0) begin
                errors++; $display("FAIL tie_grant%0d: got ready=%b%b want exactly one", i, req0_ready, req1_ready);
                break;
            end
            w = req1_ready;
            checks++;
            if (w !== exp_order[i]) begin
                errors++; $display("FAIL tie_order%0d: got %0d want %0d", i, w, exp_order[i]);
            end
            sb.push_back(w ? exp_of(1'b1, req1_a, req1_b, req1_sel) : exp_of(1'b0, req0_a, req0_b, req0_sel));
            @(negedge clk);
            if (i == 2) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else if (w) begin
                req1_a = req1_a + 8'd7;
            end else begin
                req0_a = req0_a + 8'd9;
            end
            wait_rsp(seen, ok);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++; $display("FAIL tie_rsp%0d: got no response want one", i);
                sb.delete();
                break;
            end
            e = sb.pop_front();
            checks++;
            if ({rsp_id, rsp_data, rsp_cout} !== {e.id, e.data, e.cout}) begin
                errors++; $display("FAIL tie_data%0d: got id=%0d data=%0d cout=%0d want id=%0d data=%0d cout=%0d",
                                   i, rsp_id, rsp_data, rsp_cout, e.id, e.data, e.cout);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_mul();
        int acc, seen; bit ok; exp_t e;
        issue(1'b1, 8'd16, 8'd16, OP_MUL, acc);
        wait_rsp(seen, ok);
        checks++;
        if (!ok || acc < 0 || sb.size() == 0) begin
            errors++; $display("FAIL mul_timeout: got ok=%0d acc=%0d want response", ok, acc);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        checks++;
        if (seen - acc != 4 || e.lat != 4) begin
            errors++; $display("FAIL mul_lat: got %0d want 4", seen - acc);
        end
        checks++;
        if ({rsp_id, rsp_data, rsp_cout} !== {1'b1, 8'h00, 1'b1} || rsp_data !== e.data) begin
            errors++; $display("FAIL mul_rsp: got id=%0d data=%h cout=%0d want id=1 data=00 cout=1", rsp_id, rsp_data, rsp_cout);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int acc, seen; bit ok; exp_t e; logic [10:0] snap; bit stable;
        rsp_ready = 1'b0;
        issue(1'b0, 8'd7, 8'd3, 4'b0001, acc);
        drive(1'b1, 1'b1, 8'd1, 8'd1, OP_ADD);
        wait_rsp(seen, ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++; $display("FAIL bp_timeout: got no response want one");
            sb.delete();
            rsp_ready = 1'b1;
            req1_valid = 1'b0;
            return;
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_id, rsp_data, rsp_cout, rsp_err} !== {e.id, e.data, e.cout, e.err}) begin
            errors++; $display("FAIL bp_data: got data=%0d want %0d", rsp_data, e.data);
        end
        snap = {rsp_valid, rsp_id, rsp_data, rsp_err};
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #2;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== snap || rsp_cout !== e.cout ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL bp_hold: got unstable rsp/ready/busy want held for 5 cycles");
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_no_grant_in_resp: got %0d want 0", req1_ready);
        end
        @(negedge clk); #2;
        checks++;
        if ({busy, rsp_valid, req1_ready} !== 3'b001) begin
            errors++; $display("FAIL bp_idle: got busy/valid/ready1=%b want 001", {busy, rsp_valid, req1_ready});
        end
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div0();
        int acc, seen; bit ok; exp_t e;
        issue(1'b1, 8'd9, 8'd0, OP_DIV, acc);
        wait_rsp(seen, ok);
        checks++;
        if (!ok || acc < 0 || sb.size() == 0) begin
            errors++; $display("FAIL div0_timeout: got ok=%0d want response", ok);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        checks++;
        if (seen - acc != e.lat) begin
            errors++; $display("FAIL div0_lat: got %0d want %0d", seen - acc, e.lat);
        end
        checks++;
        if ({rsp_id, rsp_data, rsp_cout, rsp_err} !== {e.id, e.data, e.cout, e.err}) begin
            errors++; $display("FAIL div0_rsp: got data=%h cout=%0d err=%0d want data=%h cout=%0d err=%0d",
                               rsp_data, rsp_cout, rsp_err, e.data, e.cout, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int acc; bit seen_rsp;
        issue(1'b0, 8'd100, 8'd5, OP_DIV, acc);
        #1;
        checks++;
        if (busy !== 1'b1 || acc < 0) begin
            errors++; $display("FAIL mid_exec: got busy=%0d acc=%0d want busy=1", busy, acc);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, busy, alu_a, alu_b, alu_sel} !== 22'h0) begin
            errors++; $display("FAIL mid_reset_vals: got %h want 0", {rsp_valid, busy, alu_a, alu_b, alu_sel});
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen_rsp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #2;
            if (rsp_valid !== 1'b0) seen_rsp = 1'b1;
        end
        checks++;
        if (seen_rsp) begin
            errors++; $display("FAIL mid_no_rsp: got rsp_valid after reset want none");
        end
        drive(1'b0, 1'b1, 8'd1, 8'd1, OP_ADD);
        drive(1'b1, 1'b1, 8'd1, 8'd1, OP_ADD);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL mid_rr_init: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 8'd0, OP_ADD);
        drive(1'b1, 1'b0, 8'd0, 8'd0, OP_ADD);
        test_reset();
        test_single();
        test_tie();
        test_mul();
        test_backpressure();
        test_div0();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
